// File: rtl/strhw_common_types.sv
// Types and constants shared across the Streebog datapath blocks.
package strhw_common_types;

    localparam int STRHW_BLOCK_BITS = 512;

    typedef logic [STRHW_BLOCK_BITS-1:0] uint512;

endpackage

// File: rtl/strhw_adder_seg.sv
// One stage of the carry-segmented adder. The stage word is packed as
// {hi_b, hi_a, lo, carry} so that the empty upper/lower fields vanish cleanly.
module strhw_adder_seg #(
    parameter int SEG  = 256,
    parameter int LO_W = 0,
    parameter int UP_W = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          valid_i,
    input  logic [2*(SEG+UP_W)+LO_W:0]    d_i,
    output logic                          valid_o,
    output logic [2*UP_W+LO_W+SEG:0]      q_o
);

    localparam int HI_W  = SEG + UP_W;
    localparam int OUT_W = 2*UP_W + LO_W + SEG + 1;

    logic [HI_W-1:0]       hi_a;
    logic [HI_W-1:0]       hi_b;
    logic [SEG:0]          seg_sum;
    logic [LO_W+SEG-1:0]   lo_new;
    logic [OUT_W-1:0]      nxt;

    assign hi_a = d_i[LO_W+HI_W : LO_W+1];
    assign hi_b = d_i[LO_W+2*HI_W : LO_W+HI_W+1];

    assign seg_sum = {1'b0, hi_a[SEG-1:0]} + {1'b0, hi_b[SEG-1:0]}
                   + {{SEG{1'b0}}, d_i[0]};

    if (LO_W > 0) begin : g_lo
        assign lo_new = {seg_sum[SEG-1:0], d_i[LO_W:1]};
    end else begin : g_no_lo
        assign lo_new = seg_sum[SEG-1:0];
    end

    if (UP_W > 0) begin : g_up
        assign nxt = {hi_b[HI_W-1:SEG], hi_a[HI_W-1:SEG], lo_new, seg_sum[SEG]};
    end else begin : g_no_up
        assign nxt = {lo_new, seg_sum[SEG]};
    end

    // Data only moves with a valid item; bubbles leave it as don't-care.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            q_o     <= '0;
        end else if (en_i) begin
            valid_o <= valid_i;
            if (valid_i) q_o <= nxt;
        end
    end

endmodule

// File: rtl/strhw_adder_pipe.sv
// Pipelined modular adder: (a + b + cin) mod 2^WIDTH over SEGS segment stages,
// valid/ready flow control with per-stage bubble collapsing.
module strhw_adder_pipe
    import strhw_common_types::*;
#(
    parameter int WIDTH = STRHW_BLOCK_BITS,
    parameter int SEGS  = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int SEG = WIDTH / ((SEGS < 1) ? 1 : SEGS);

    if (SEGS < 1 || (WIDTH % SEGS) != 0) begin : g_bad_cfg
        $error("strhw_adder_pipe: WIDTH must be a multiple of SEGS >= 1");
    end

    for (genvar k = 0; k < SEGS; k++) begin : g_st
        localparam int LO_W  = k * SEG;
        localparam int UP_W  = WIDTH - (k + 1) * SEG;
        localparam int IN_W  = 2*(SEG + UP_W) + LO_W + 1;
        localparam int OUT_W = 2*UP_W + LO_W + SEG + 1;

        logic [IN_W-1:0]  d;
        logic [OUT_W-1:0] q;
        logic             vin;
        logic             v;
        logic             en;

        if (k == 0) begin : g_head
            assign d   = {b_i, a_i, cin_i};
            assign vin = valid_i;
        end else begin : g_link
            assign d   = g_st[k-1].q;
            assign vin = g_st[k-1].v;
        end

        // A stage may advance when it is empty or the stage after it advances.
        if (k == SEGS - 1) begin : g_tail_en
            assign en = !v || ready_i;
        end else begin : g_mid_en
            assign en = !v || g_st[k+1].en;
        end

        strhw_adder_seg #(
            .SEG  (SEG),
            .LO_W (LO_W),
            .UP_W (UP_W)
        ) u_seg (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (en),
            .valid_i (vin),
            .d_i     (d),
            .valid_o (v),
            .q_o     (q)
        );
    end

    assign ready_o          = g_st[0].en;
    assign valid_o          = g_st[SEGS-1].v;
    assign {sum_o, cout_o}  = g_st[SEGS-1].q;

endmodule

// File: tb/tb_strhw_adder_pipe.sv
// Bench for strhw_adder_pipe: directed vector table, latency/backpressure/reset
// sequences, and a scoreboard fed by a plain-arithmetic reference model.
module tb_strhw_adder_pipe;

    localparam int W    = 512;
    localparam int SEGS = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i, ready_i, cin_i, v4_i;
    logic [W-1:0] a_i, b_i;
    logic         ready_o, valid_o, cout_o;
    logic [W-1:0] sum_o;
    logic         ready4_o, valid4_o, cout4_o;
    logic [W-1:0] sum4_o;

    int total = 0;
    int bad   = 0;
    int nin   = 0;
    int nout  = 0;
    int run   = 0;
    int max_run = 0;
    logic [W:0] sbq[$];

    always #5 clk = ~clk;

    strhw_adder_pipe #(.WIDTH(W), .SEGS(SEGS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .valid_o(valid_o),
        .ready_i(ready_i), .sum_o(sum_o), .cout_o(cout_o));

    strhw_adder_pipe #(.WIDTH(W), .SEGS(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v4_i), .ready_o(ready4_o),
        .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .valid_o(valid4_o),
        .ready_i(ready_i), .sum_o(sum4_o), .cout_o(cout4_o));

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic [W-1:0] rnd512();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard: transfers are decided by values stable at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            run = 0;
        end else begin
            if (valid_i && ready_o) begin
                sbq.push_back(ref_add(a_i, b_i, cin_i));
                nin++;
            end
            if (valid_o && ready_i) begin
                if (sbq.size() == 0) chk("sb_unexpected", {cout_o, sum_o}, '0);
                else chk("sb_result", {cout_o, sum_o}, sbq.pop_front());
                nout++;
            end
            run = valid_o ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
    end

    // Single item into an empty pipe with ready_i=1; checks exact latency.
    task automatic send_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic [W-1:0] es, input logic ec);
        int early;
        int waited;
        early = 0;
        waited = 0;
        a_i = a; b_i = b; cin_i = c; ready_i = 1'b1; valid_i = 1'b1;
        while (!ready_o && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({nm, "_ready"}, {{W{1'b0}}, ready_o}, {{W{1'b0}}, 1'b1});
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int i = 0; i < SEGS - 1; i++) begin
            if (valid_o) early++;
            @(posedge clk); #1;
        end
        chk({nm, "_early"}, early, 0);
        chk({nm, "_valid"}, {{W{1'b0}}, valid_o}, {{W{1'b0}}, 1'b1});
        chk({nm, "_sum"}, {cout_o, sum_o}, {ec, es});
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] one;
        int base;
        int stalls;
        int stale;
        ones = {W{1'b1}};
        one  = {{(W-1){1'b0}}, 1'b1};

        vecs[0] = '{a: 512'd1, b: 512'd2, cin: 1'b0, s: 512'd3, co: 1'b0};
        vecs[1] = '{a: (one << 256) - one, b: one, cin: 1'b0, s: one << 256, co: 1'b0};
        vecs[2] = '{a: ones, b: 512'd0, cin: 1'b1, s: 512'd0, co: 1'b1};
        vecs[3] = '{a: 512'hFFFF_FE00, b: 512'd512, cin: 1'b0, s: 512'h1_0000_0000, co: 1'b0};
        vecs[4] = '{a: ones, b: ones, cin: 1'b1, s: ones, co: 1'b1};
        vecs[5] = '{a: one << 511, b: one << 511, cin: 1'b0, s: 512'd0, co: 1'b1};
        vecs[6] = '{a: 512'd0, b: 512'd0, cin: 1'b1, s: 512'd1, co: 1'b0};

        rst_n = 1'b0; valid_i = 1'b0; v4_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; cin_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {{W{1'b0}}, valid_o}, '0);
        chk("rst_sum", {cout_o, sum_o}, '0);
        chk("rst_ready", {{W{1'b0}}, ready_o}, {{W{1'b0}}, 1'b1});
        chk("rst4_valid", {{W{1'b0}}, valid4_o}, '0);
        #1 rst_n = 1'b1;
        chk("rel_ready", {{W{1'b0}}, ready_o}, {{W{1'b0}}, 1'b1});
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 7; i++)
            send_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                     vecs[i].s, vecs[i].co);
        @(posedge clk); #1;

        // Four-segment instance: carry crossing the 128-bit boundary
        a_i = (one << 128) - one; b_i = one; cin_i = 1'b0; v4_i = 1'b1;
        @(posedge clk); #1;
        v4_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("seg4_early", {{W{1'b0}}, valid4_o}, '0);
        @(posedge clk); #1;
        chk("seg4_valid", {{W{1'b0}}, valid4_o}, {{W{1'b0}}, 1'b1});
        chk("seg4_sum", {cout4_o, sum4_o}, {1'b0, one << 128});
        @(posedge clk); #1;

        // Random valid/ready at 50%, 10 items
        base = nout;
        begin
            int b_in;
            b_in = nin;
            for (int cyc = 0; cyc < 2000 && (nout - base) < 10; cyc++) begin
                @(posedge clk); #1;
                ready_i = ($urandom % 2) == 1;
                if ((nin - b_in) < 10 && ($urandom % 2) == 1) begin
                    valid_i = 1'b1; a_i = rnd512(); b_i = rnd512(); cin_i = $urandom % 2;
                end else begin
                    valid_i = 1'b0;
                end
            end
        end
        valid_i = 1'b0; ready_i = 1'b1;
        chk("rand_count", nout - base, 10);
        repeat (SEGS + 2) @(posedge clk);
        #1;

        // Backpressure: ready_o must fall after exactly SEGS accepts
        ready_i = 1'b0;
        base = nin;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; a_i = rnd512(); b_i = rnd512(); cin_i = $urandom % 2;
            @(posedge clk); #1;
        end
        chk("bp_accepted", nin - base, SEGS);
        chk("bp_ready_low", {{W{1'b0}}, ready_o}, '0);
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (SEGS + 2) @(posedge clk);
        #1;

        // Back-to-back: 100 items, output must be gap-free
        max_run = 0;
        stalls = 0;
        base = nout;
        for (int i = 0; i < 100; i++) begin
            valid_i = 1'b1; a_i = rnd512(); b_i = rnd512(); cin_i = $urandom % 2;
            if (!ready_o) stalls++;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        repeat (SEGS + 3) @(posedge clk);
        #1;
        chk("b2b_stalls", stalls, 0);
        chk("b2b_run", max_run, 100);
        chk("b2b_count", nout - base, 100);

        // Reset with a full, stalled pipe
        ready_i = 1'b0;
        for (int i = 0; i < SEGS + 1; i++) begin
            valid_i = 1'b1; a_i = rnd512(); b_i = rnd512(); cin_i = 1'b1;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        chk("pre_rst_valid", {{W{1'b0}}, valid_o}, {{W{1'b0}}, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {{W{1'b0}}, valid_o}, '0);
        chk("mid_rst_ready", {{W{1'b0}}, ready_o}, {{W{1'b0}}, 1'b1});
        @(posedge clk); #2;
        rst_n = 1'b1;
        ready_i = 1'b1;
        stale = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (valid_o) stale++;
        end
        chk("post_rst_stale", stale, 0);
        send_one("post_rst", 512'h1234_5678, 512'hFFFF_FFFF, 1'b1, 512'h1_1234_5678, 1'b0);
        @(posedge clk); #1;
        chk("sb_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
